main: RTL and testbench

- Top-level of the FPGA graphics front end.
- Receives one geometry frame over a mode-0 SPI slave link:
  - 4 homogeneous vertices (x,y,z,w in signed Q4.12);
  - 4 lines, each given as two 16-bit vertex indices.
- On frame completion, converts each vertex's x,y from NDC to integer screen coordinates, stores them, and reports frame validity on io_led.
- Screen table of the last valid frame is read back on MISO during the next transaction.

---
 rtl/main_pkg.sv | 68 ++++++
 rtl/main_if.sv | 10 +
 rtl/main_spi_slave_word.sv | 81 ++++++++
 rtl/main.sv | 157 +++++++++++++++
 tb/tb_main.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/main_pkg.sv
// Shared types, frame constants and the NDC-to-screen mapping for the graphics front end.
package main_pkg;

    localparam int WORD_W         = 16;
    localparam int FRAC           = 12;
    localparam int NUM_VERTS      = 4;
    localparam int NUM_LINES      = 4;
    localparam int SCREEN_W       = 320;
    localparam int SCREEN_H       = 240;
    localparam int VERT_WORDS     = 4 * NUM_VERTS;
    localparam int IDX_WORDS      = 2 * NUM_LINES;
    localparam int FRAME_WORDS    = VERT_WORDS + IDX_WORDS;
    localparam int READBACK_WORDS = 2 * NUM_VERTS;

    typedef logic signed [WORD_W-1:0] fixed_t;

    localparam fixed_t ONE_Q = 16'sh1000;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
        fixed_t w;
    } vertex_t;

    typedef logic [8:0] sx_t;
    typedef logic [7:0] sy_t;

    typedef enum logic {
        XF_IDLE,
        XF_RUN
    } xf_state_e;

    // Shifted sum in [0, 2.0] Q4.12 scaled to half a screen dimension.
    function automatic logic signed [25:0] scale_q(input logic signed [16:0] sum, input int half);
        logic signed [25:0] prod;
        prod = $signed({{9{sum[16]}}, sum}) * $signed(26'(half));
        return prod >>> FRAC;
    endfunction

    function automatic sx_t to_sx(input fixed_t x);
        logic signed [16:0] sum;
        logic signed [25:0] s;
        sum = {x[15], x} + {ONE_Q[15], ONE_Q};
        s   = scale_q(sum, SCREEN_W / 2);
        if (s < 26'sd0)
            return '0;
        else if (s > 26'(SCREEN_W - 1))
            return sx_t'(SCREEN_W - 1);
        else
            return sx_t'(s);
    endfunction

    // Screen y grows downward, so NDC y is flipped.
    function automatic sy_t to_sy(input fixed_t y);
        logic signed [16:0] sum;
        logic signed [25:0] s;
        sum = {ONE_Q[15], ONE_Q} - {y[15], y};
        s   = scale_q(sum, SCREEN_H / 2);
        if (s < 26'sd0)
            return '0;
        else if (s > 26'(SCREEN_H - 1))
            return sy_t'(SCREEN_H - 1);
        else
            return sy_t'(s);
    endfunction

endpackage

// File: rtl/main_if.sv
// SPI pin bundle between an SPI master and the graphics front end.
interface main_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs, output mosi, input miso);
    modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/main_spi_slave_word.sv
// Mode-0 SPI slave: pin synchronisers, edge detection, 16-bit word shift-in and shift-out.
module spi_slave_word
    import main_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    main_if.slave             spi,
    input  logic [WORD_W-1:0] tx_word_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    output logic              cs_fall_o,
    output logic              cs_rise_o
);

    // Stages [1:0] synchronise, stage [2] holds the previous value for edge detection.
    logic [2:0]        sclk_q;
    logic [2:0]        cs_q;
    logic [1:0]        mosi_q;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0] rx_q, rx_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic              miso_q, miso_d;

    logic sclk_rise, sclk_fall, cs_active;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall_o = ~cs_q[1] & cs_q[2];
    assign cs_rise_o = cs_q[1] & ~cs_q[2];
    assign cs_active = ~cs_q[1];

    assign word_valid_o = sclk_rise & cs_active & (bit_cnt_q == 4'd15);
    assign word_o       = {rx_q, mosi_q[1]};
    assign spi.miso     = miso_q;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        if (cs_fall_o) begin
            bit_cnt_d = '0;
            miso_d    = tx_word_i[WORD_W-1];
            tx_d      = {tx_word_i[WORD_W-2:0], 1'b0};
        end else if (cs_rise_o) begin
            miso_d = 1'b0;
        end else if (cs_active) begin
            if (sclk_rise) begin
                rx_d      = {rx_q[WORD_W-3:0], mosi_q[1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
                // Next word is staged here; its MSB goes out on the following falling edge.
                if (bit_cnt_q == 4'd15)
                    tx_d = tx_word_i;
            end else if (sclk_fall) begin
                miso_d = tx_q[WORD_W-1];
                tx_d   = {tx_q[WORD_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q    <= '0;
            cs_q      <= '0;
            mosi_q    <= '0;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[1:0], spi.sclk};
            cs_q      <= {cs_q[1:0], spi.cs};
            mosi_q    <= {mosi_q[0], spi.mosi};
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
        end
    end

endmodule

// File: rtl/main.sv
// Graphics front end top: SPI frame store, vertex-to-screen transform sequencer, LED and clear button.
module main
    import main_pkg::*;
(
    input  logic       clock,
    input  logic       io_aresetn,
    input  logic       reset,
    input  logic [3:0] io_btn,
    output logic       io_led,
    input  logic       io_spi_sclk,
    input  logic       io_spi_cs,
    input  logic       io_spi_mosi,
    output logic       io_spi_miso
);

    main_if spi_bus ();

    assign spi_bus.sclk = io_spi_sclk;
    assign spi_bus.cs   = io_spi_cs;
    assign spi_bus.mosi = io_spi_mosi;
    assign io_spi_miso  = spi_bus.miso;

    logic              word_valid, cs_fall, cs_rise;
    logic [WORD_W-1:0] word, tx_word;

    spi_slave_word u_spi (
        .clk_i        (clock),
        .rst_ni       (io_aresetn),
        .spi          (spi_bus.slave),
        .tx_word_i    (tx_word),
        .word_valid_o (word_valid),
        .word_o       (word),
        .cs_fall_o    (cs_fall),
        .cs_rise_o    (cs_rise)
    );

    logic [3:0]        btn_s1_q, btn_s2_q;
    logic [4:0]        word_cnt_q, word_cnt_d;
    vertex_t           verts_q [NUM_VERTS];
    logic [WORD_W-1:0] idx_q [IDX_WORDS];
    sx_t               sx_q [NUM_VERTS];
    sy_t               sy_q [NUM_VERTS];
    logic              frame_valid_q, frame_valid_d;
    xf_state_e         state_q, state_d;
    logic [1:0]        vcnt_q, vcnt_d;
    logic              xf_start, xf_we, xf_done, clr, word_store;
    logic [IDX_WORDS-1:0] idx_ok;
    logic [NUM_VERTS-1:0] unused_zw;
    logic [5:0]        rb_idx;
    logic              unused_ok;

    genvar gi;
    generate
        for (gi = 0; gi < IDX_WORDS; gi++) begin : g_idx_ok
            assign idx_ok[gi] = idx_q[gi] < 16'(NUM_VERTS);
        end
        for (gi = 0; gi < NUM_VERTS; gi++) begin : g_zw
            assign unused_zw[gi] = ^{verts_q[gi].z, verts_q[gi].w};
        end
    endgenerate

    assign unused_ok  = ^{reset, btn_s2_q[3:1], unused_zw};
    assign clr        = btn_s2_q[0];
    assign word_store = word_valid && (word_cnt_q < 5'(FRAME_WORDS));
    assign xf_start   = cs_rise && (word_cnt_q == 5'(FRAME_WORDS)) && (&idx_ok);
    assign io_led     = frame_valid_q;

    // Readback word for the next slot: slot 0 on cs fall, otherwise the word after the current one.
    always_comb begin
        rb_idx  = cs_fall ? 6'd0 : ({1'b0, word_cnt_q} + 6'd1);
        tx_word = '0;
        if (rb_idx < 6'(READBACK_WORDS))
            tx_word = rb_idx[0] ? {8'b0, sy_q[rb_idx[2:1]]} : {7'b0, sx_q[rb_idx[2:1]]};
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (cs_fall)
            word_cnt_d = '0;
        else if (word_store)
            word_cnt_d = word_cnt_q + 5'd1;
    end

    always_comb begin
        state_d       = state_q;
        vcnt_d        = vcnt_q;
        xf_we         = 1'b0;
        xf_done       = 1'b0;
        frame_valid_d = frame_valid_q;
        case (state_q)
            XF_IDLE: begin
                if (xf_start) begin
                    state_d = XF_RUN;
                    vcnt_d  = '0;
                end
            end
            XF_RUN: begin
                xf_we  = 1'b1;
                vcnt_d = vcnt_q + 2'd1;
                if (vcnt_q == 2'(NUM_VERTS - 1)) begin
                    xf_done = 1'b1;
                    state_d = XF_IDLE;
                end
            end
            default: state_d = XF_IDLE;
        endcase
        if (cs_rise && !xf_start)
            frame_valid_d = 1'b0;
        if (xf_done)
            frame_valid_d = 1'b1;
        // Clear has the last word, even over a completing transform.
        if (clr)
            frame_valid_d = 1'b0;
    end

    always_ff @(posedge clock or negedge io_aresetn) begin
        if (!io_aresetn) begin
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            word_cnt_q    <= '0;
            frame_valid_q <= 1'b0;
            state_q       <= XF_IDLE;
            vcnt_q        <= '0;
            for (int i = 0; i < NUM_VERTS; i++) begin
                verts_q[i] <= '0;
                sx_q[i]    <= '0;
                sy_q[i]    <= '0;
            end
            for (int i = 0; i < IDX_WORDS; i++)
                idx_q[i] <= '0;
        end else begin
            btn_s1_q      <= io_btn;
            btn_s2_q      <= btn_s1_q;
            word_cnt_q    <= word_cnt_d;
            frame_valid_q <= frame_valid_d;
            state_q       <= state_d;
            vcnt_q        <= vcnt_d;
            if (word_store) begin
                if (word_cnt_q < 5'(VERT_WORDS)) begin
                    case (word_cnt_q[1:0])
                        2'd0:    verts_q[word_cnt_q[3:2]].x <= word;
                        2'd1:    verts_q[word_cnt_q[3:2]].y <= word;
                        2'd2:    verts_q[word_cnt_q[3:2]].z <= word;
                        default: verts_q[word_cnt_q[3:2]].w <= word;
                    endcase
                end else begin
                    idx_q[word_cnt_q[2:0]] <= word;
                end
            end
            if (xf_we) begin
                sx_q[vcnt_q] <= to_sx(verts_q[vcnt_q].x);
                sy_q[vcnt_q] <= to_sy(verts_q[vcnt_q].y);
            end
        end
    end

endmodule

// File: tb/tb_main.sv
// Bench for the graphics front end: frame vectors over SPI, readback scoreboard, clear and reset sequences.
module tb_main;

    logic       clock = 1'b0;
    logic       io_aresetn;
    logic       reset;
    logic [3:0] io_btn;
    logic       io_led;

    main_if tb_spi ();

    always #5 clock = ~clock;

    main dut (
        .clock       (clock),
        .io_aresetn  (io_aresetn),
        .reset       (reset),
        .io_btn      (io_btn),
        .io_led      (io_led),
        .io_spi_sclk (tb_spi.sclk),
        .io_spi_cs   (tb_spi.cs),
        .io_spi_mosi (tb_spi.mosi),
        .io_spi_miso (tb_spi.miso)
    );

    typedef struct {
        int                nwords;
        logic [0:3][15:0]  xs;
        logic [0:3][15:0]  ys;
        logic [0:7][15:0]  idx;
        bit                valid;
        logic [0:3][8:0]   esx;
        logic [0:3][7:0]   esy;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          errors = 0;
    int          hp = 6;
    int          m_sx [4];
    int          m_sy [4];
    logic [15:0] exp_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] txn_word(input int v, input int k);
        if (k < 16) begin
            case (k % 4)
                0:       return vecs[v].xs[k/4];
                1:       return vecs[v].ys[k/4];
                2:       return 16'h0000;
                default: return 16'h1000;
            endcase
        end
        return vecs[v].idx[k-16];
    endfunction

    task automatic spi_word(input logic [15:0] w, output logic [15:0] r);
        for (int b = 15; b >= 0; b--) begin
            tb_spi.mosi = w[b];
            repeat (hp) @(negedge clock);
            r[b] = tb_spi.miso;
            tb_spi.sclk = 1'b1;
            repeat (hp) @(negedge clock);
            tb_spi.sclk = 1'b0;
        end
    endtask

    task automatic run_txn(input int v, input bit clr_mid);
        logic [15:0] r, e;
        for (int k = 0; k < vecs[v].nwords; k++)
            exp_q.push_back(k < 8 ? ((k % 2 == 0) ? 16'(m_sx[k/2]) : 16'(m_sy[k/2])) : 16'h0000);
        tb_spi.cs = 1'b0;
        repeat (hp) @(negedge clock);
        for (int k = 0; k < vecs[v].nwords; k++) begin
            if (clr_mid)
                io_btn[0] = (k == 2);
            spi_word(txn_word(v, k), r);
            e = exp_q.pop_front();
            check($sformatf("vec%0d_rd%0d", v, k), 32'(r), 32'(e));
        end
        io_btn = '0;
        repeat (hp) @(negedge clock);
        tb_spi.cs = 1'b1;
        if (vecs[v].valid) begin
            for (int i = 0; i < 12 && io_led !== 1'b1; i++)
                @(negedge clock);
            check($sformatf("vec%0d_led", v), 32'(io_led), 32'd1);
            for (int j = 0; j < 4; j++) begin
                m_sx[j] = int'(vecs[v].esx[j]);
                m_sy[j] = int'(vecs[v].esy[j]);
            end
        end else begin
            repeat (12) @(negedge clock);
            check($sformatf("vec%0d_led", v), 32'(io_led), 32'd0);
        end
        check($sformatf("vec%0d_miso_idle", v), 32'(tb_spi.miso), 32'd0);
        $display("txn vec%0d: %0d words, clr_mid=%0b, led=%0b", v, vecs[v].nwords, clr_mid, io_led);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i].nwords = 8;
            vecs[i].xs     = '0;
            vecs[i].ys     = '0;
            vecs[i].idx    = '0;
            vecs[i].valid  = 1'b0;
            vecs[i].esx    = '0;
            vecs[i].esy    = '0;
        end
        // Square at +/-0.5
        vecs[0].nwords = 24;
        vecs[0].xs     = {16'hF800, 16'h0800, 16'h0800, 16'hF800};
        vecs[0].ys     = {16'hF800, 16'hF800, 16'h0800, 16'h0800};
        vecs[0].valid  = 1'b1;
        vecs[0].esx    = {9'd80, 9'd240, 9'd240, 9'd80};
        vecs[0].esy    = {8'd180, 8'd180, 8'd60, 8'd60};
        // Short frame
        vecs[2].nwords = 20;
        vecs[2].xs     = {16'h1000, 16'h1000, 16'h1000, 16'h1000};
        vecs[2].ys     = {16'h1000, 16'h1000, 16'h1000, 16'h1000};
        // Clamping extremes
        vecs[4].nwords = 24;
        vecs[4].xs     = {16'h7FFF, 16'hC000, 16'h0000, 16'h1000};
        vecs[4].ys     = {16'h8000, 16'h7FFF, 16'h0000, 16'hF000};
        vecs[4].idx    = {16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd0};
        vecs[4].valid  = 1'b1;
        vecs[4].esx    = {9'd319, 9'd0, 9'd160, 9'd319};
        vecs[4].esy    = {8'd239, 8'd0, 8'd120, 8'd239};
        // Bad index
        vecs[5]        = vecs[0];
        vecs[5].idx[5] = 16'h0004;
        vecs[5].valid  = 1'b0;
        vecs[5].esx    = '0;
        vecs[5].esy    = '0;
        // Rounding and just-below-zero cases
        vecs[6].nwords = 24;
        vecs[6].xs     = {16'h0400, 16'hFC00, 16'h0001, 16'hEFFF};
        vecs[6].ys     = {16'h0400, 16'hFC00, 16'h0FFF, 16'hF001};
        vecs[6].idx    = {16'd3, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0, 16'd1, 16'd2};
        vecs[6].valid  = 1'b1;
        vecs[6].esx    = {9'd200, 9'd120, 9'd160, 9'd0};
        vecs[6].esy    = {8'd90, 8'd150, 8'd0, 8'd239};

        for (int j = 0; j < 4; j++) begin
            m_sx[j] = 0;
            m_sy[j] = 0;
        end

        io_aresetn  = 1'b0;
        reset       = 1'b0;
        io_btn      = '0;
        tb_spi.sclk = 1'b0;
        tb_spi.cs   = 1'b1;
        tb_spi.mosi = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_led", 32'(io_led), 32'd0);
        check("rst_miso", 32'(tb_spi.miso), 32'd0);
        io_aresetn = 1'b1;
        repeat (10) @(negedge clock);
        check("idle_led", 32'(io_led), 32'd0);
        check("idle_miso", 32'(tb_spi.miso), 32'd0);

        hp = 25;
        run_txn(0, 1'b0);
        hp = 6;
        for (int v = 1; v < 8; v++)
            run_txn(v, 1'b0);

        run_txn(0, 1'b0);
        run_txn(6, 1'b1);

        // Reset in the middle of a word while the frame is valid
        tb_spi.cs = 1'b0;
        repeat (hp) @(negedge clock);
        for (int b = 0; b < 8; b++) begin
            tb_spi.mosi = 1'b1;
            repeat (hp) @(negedge clock);
            tb_spi.sclk = 1'b1;
            repeat (hp) @(negedge clock);
            tb_spi.sclk = 1'b0;
        end
        repeat (hp) @(negedge clock);
        check("prerst_led", 32'(io_led), 32'd1);
        check("prerst_miso", 32'(tb_spi.miso), 32'((m_sx[0] >> 7) & 1));
        tb_spi.sclk = 1'b1;
        repeat (2) @(negedge clock);
        io_aresetn = 1'b0;
        repeat (3) @(negedge clock);
        check("inrst_led", 32'(io_led), 32'd0);
        check("inrst_miso", 32'(tb_spi.miso), 32'd0);
        io_aresetn  = 1'b1;
        tb_spi.sclk = 1'b0;
        repeat (hp) @(negedge clock);
        tb_spi.cs = 1'b1;
        repeat (20) @(negedge clock);
        check("postrst_led", 32'(io_led), 32'd0);
        $display("txn reset-mid-word: led=%0b miso=%0b", io_led, tb_spi.miso);
        for (int j = 0; j < 4; j++) begin
            m_sx[j] = 0;
            m_sy[j] = 0;
        end
        run_txn(4, 1'b0);
        run_txn(1, 1'b0);

        // Unused buttons are ignored; button 0 clears but keeps the table
        run_txn(0, 1'b0);
        io_btn = 4'b1110;
        repeat (6) @(negedge clock);
        check("btn_hi_led", 32'(io_led), 32'd1);
        io_btn = 4'b0001;
        repeat (5) @(negedge clock);
        io_btn = 4'b0000;
        repeat (5) @(negedge clock);
        check("clr_led", 32'(io_led), 32'd0);
        $display("txn clear pulse: led=%0b", io_led);
        run_txn(1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
